// File: rtl/dsi_lane_pkg.sv
// rtl/dsi_lane_pkg.sv - D-PHY lane bridge state encoding, RX FIFO word layout and bit-reverse helper
package dsi_lane_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        FLUSH = 3'd2,
        DROP  = 3'd3,
        ABORT = 3'd4
    } lane_state_t;

    localparam int BYTE_W   = 8;
    localparam int LAST_BIT = 8;
    localparam int ERR_BIT  = 9;
    localparam int WORD_W   = 10;

    // Shared with the TX bridge so both ends agree on lane bit order.
    function automatic logic [BYTE_W-1:0] bit_reverse(input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] r;
        for (int i = 0; i < BYTE_W; i++) begin
            r[i] = b[BYTE_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/lane_to_fifo_bridge.sv
// rtl/lane_to_fifo_bridge.sv - D-PHY lane RX byte stream to tagged RX FIFO words (LANE_RX_BIT_REVERSE_EN optional)
module lane_to_fifo_bridge
    import dsi_lane_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_active,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_err,
    input  logic              fifo_full,
    output logic              fifo_write,
    output logic [WORD_W-1:0] fifo_data,
    output logic              pkt_done,
    output logic [LEN_W-1:0]  pkt_len,
    output logic              pkt_err,
    output logic              overflow
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    lane_state_t       state_q, state_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  pkt_len_q;
    logic              late_q, late_d;
    logic              armed_q;
    logic [7:0]        rx_byte;
    logic [LEN_W-1:0]  len_inc;
    logic              late_byte;

`ifdef LANE_RX_BIT_REVERSE_EN
    assign rx_byte = bit_reverse(rx_data);
`else
    assign rx_byte = rx_data;
`endif

    assign len_inc   = (len_q == '1) ? len_q : len_q + LEN_ONE;
    assign late_byte = rx_active & rx_valid;
    assign pkt_len   = pkt_done ? len_q : pkt_len_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        len_d       = len_q;
        late_d      = late_q;
        fifo_write  = 1'b0;
        fifo_data   = {2'b00, hold_q};
        pkt_done    = 1'b0;
        pkt_err     = 1'b0;
        overflow    = 1'b0;

        case (state_q)
            IDLE: begin
                len_d       = '0;
                hold_full_d = 1'b0;
                late_d      = 1'b0;
                // armed stays low after reset until the lane is seen idle once.
                if (rx_active && armed_q) begin
                    if (rx_err) begin
                        state_d = DROP;
                    end else begin
                        state_d = RECV;
                        if (rx_valid) begin
                            hold_d      = rx_byte;
                            hold_full_d = 1'b1;
                            len_d       = LEN_ONE;
                        end
                    end
                end
            end

            RECV: begin
                if (!rx_active) begin
                    state_d = hold_full_q ? FLUSH : IDLE;
                end else if (rx_err) begin
                    state_d     = DROP;
                    hold_full_d = 1'b0;
                end else if (rx_valid) begin
                    if (!hold_full_q) begin
                        hold_d      = rx_byte;
                        hold_full_d = 1'b1;
                        len_d       = len_inc;
                    end else if (!fifo_full) begin
                        fifo_write = 1'b1;
                        hold_d     = rx_byte;
                        len_d      = len_inc;
                    end else begin
                        overflow    = 1'b1;
                        state_d     = DROP;
                        hold_full_d = 1'b0;
                    end
                end
            end

            FLUSH, ABORT: begin
                // Bytes of a burst that starts before the terminator is out are lost.
                if (late_byte) begin
                    overflow = 1'b1;
                    late_d   = 1'b1;
                end
                if (state_q == ABORT) begin
                    fifo_data           = '0;
                    fifo_data[LAST_BIT] = 1'b1;
                    fifo_data[ERR_BIT]  = 1'b1;
                end else begin
                    fifo_data[LAST_BIT] = 1'b1;
                end
                if (!fifo_full) begin
                    fifo_write  = 1'b1;
                    pkt_done    = 1'b1;
                    pkt_err     = (state_q == ABORT);
                    hold_full_d = 1'b0;
                    len_d       = '0;
                    late_d      = 1'b0;
                    state_d     = (late_q || late_byte) ? DROP : IDLE;
                end
            end

            DROP: begin
                hold_full_d = 1'b0;
                if (!rx_active) begin
                    state_d = ABORT;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            len_q       <= '0;
            pkt_len_q   <= '0;
            late_q      <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            len_q       <= len_d;
            late_q      <= late_d;
            armed_q     <= armed_q | ~rx_active;
            if (pkt_done) begin
                pkt_len_q <= len_q;
            end
        end
    end

endmodule

// File: tb/tb_lane_to_fifo_bridge.sv
// tb/tb_lane_to_fifo_bridge.sv - self-checking bench for lane_to_fifo_bridge (follows LANE_RX_BIT_REVERSE_EN)
`timescale 1ns/1ps
module tb_lane_to_fifo_bridge;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx_active = 1'b0;
    logic             rx_valid = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_err = 1'b0;
    logic             fifo_full = 1'b0;
    logic             fifo_write;
    logic [9:0]       fifo_data;
    logic             pkt_done;
    logic [LEN_W-1:0] pkt_len;
    logic             pkt_err;
    logic             overflow;

    int checks = 0;
    int failures = 0;
    int n_writes = 0;
    int n_done = 0;
    int n_ovf = 0;

    logic [9:0]  exp_words[$];
    logic [16:0] exp_pkts[$];

    typedef struct {
        int          n;
        logic [39:0] d;
        int          err_at;
        int          full_at;
        int          exp_len;
        bit          exp_err;
        int          exp_writes;
        int          exp_done;
        int          exp_ovf;
    } vec_t;

    vec_t vecs[7];

    lane_to_fifo_bridge #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_active  (rx_active),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_err     (rx_err),
        .fifo_full  (fifo_full),
        .fifo_write (fifo_write),
        .fifo_data  (fifo_data),
        .pkt_done   (pkt_done),
        .pkt_len    (pkt_len),
        .pkt_err    (pkt_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] stored(input logic [7:0] b);
`ifdef LANE_RX_BIT_REVERSE_EN
        logic [7:0] r;
        r = {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
        return r;
`else
        return b;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic observe();
        logic [16:0] e;
        if (rst_n) begin
            if (fifo_write) begin
                n_writes++;
                if (exp_words.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=0x%0h required=none", fifo_data);
                end else begin
                    check("fifo_word", 32'(fifo_data), 32'(exp_words.pop_front()));
                end
            end
            if (pkt_done) begin
                n_done++;
                if (exp_pkts.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pkt_done actual_len=%0d required=none", pkt_len);
                end else begin
                    e = exp_pkts.pop_front();
                    check("pkt_len", 32'(pkt_len), 32'(e[15:0]));
                    check("pkt_err", 32'(pkt_err), 32'(e[16]));
                end
            end
            if (overflow) n_ovf++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic end_burst();
        rx_valid  = 1'b0;
        rx_err    = 1'b0;
        fifo_full = 1'b0;
        rx_active = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int w0, d0, o0, good;
        bit bad;
        logic [7:0] b;
        w0 = n_writes; d0 = n_done; o0 = n_ovf;
        bad  = (v.err_at >= 0) || (v.full_at >= 0);
        good = (v.err_at >= 0) ? v.err_at : (v.full_at >= 0) ? v.full_at : v.n;
        for (int i = 0; i < v.n; i++) begin
            b = v.d[8*i +: 8];
            if (!bad) exp_words.push_back({1'b0, (i == v.n - 1), stored(b)});
            else if (i < good - 1) exp_words.push_back({2'b00, stored(b)});
        end
        if (bad) exp_words.push_back(10'h300);
        if (v.exp_done > 0) exp_pkts.push_back({v.exp_err, 16'(v.exp_len)});

        rx_active = 1'b1;
        tick();
        for (int i = 0; i < v.n; i++) begin
            rx_valid  = 1'b1;
            rx_data   = v.d[8*i +: 8];
            rx_err    = (i == v.err_at);
            fifo_full = (i == v.full_at);
            tick();
        end
        end_burst();
        repeat (4) tick();
        check($sformatf("vec%0d_writes", idx), 32'(n_writes - w0), 32'(v.exp_writes));
        check($sformatf("vec%0d_done", idx), 32'(n_done - d0), 32'(v.exp_done));
        check($sformatf("vec%0d_ovf", idx), 32'(n_ovf - o0), 32'(v.exp_ovf));
        if (v.exp_done > 0) check($sformatf("vec%0d_len_held", idx), 32'(pkt_len), 32'(v.exp_len));
    endtask

    task automatic send_bytes(input logic [23:0] d);
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1;
            rx_data  = d[8*i +: 8];
            tick();
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_fifo_write"}, 32'(fifo_write), 32'd0);
        check({tag, "_fifo_data"}, 32'(fifo_data), 32'd0);
        check({tag, "_pkt_done"}, 32'(pkt_done), 32'd0);
        check({tag, "_pkt_len"}, 32'(pkt_len), 32'd0);
        check({tag, "_pkt_err"}, 32'(pkt_err), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        int w0, d0, o0;
        vecs[0] = '{3, 40'h00_0003_0201, -1, -1, 3, 1'b0, 3, 1, 0};
        vecs[1] = '{1, 40'h00_0000_00A5, -1, -1, 1, 1'b0, 1, 1, 0};
        vecs[2] = '{0, 40'h00_0000_0000, -1, -1, 0, 1'b0, 0, 0, 0};
        vecs[3] = '{4, 40'h00_4433_2211, -1,  1, 1, 1'b1, 1, 1, 1};
        vecs[4] = '{5, 40'h55_4433_2211,  1, -1, 1, 1'b1, 1, 1, 0};
        vecs[5] = '{5, 40'h5A_EFBE_ADDE, -1, -1, 5, 1'b0, 5, 1, 0};
        vecs[6] = '{4, 40'h00_0403_0201,  3, -1, 3, 1'b1, 3, 1, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Final write held off while the FIFO is full, released on the exact cycle it drains.
        w0 = n_writes; d0 = n_done;
        exp_words.push_back({2'b00, stored(8'h10)});
        exp_words.push_back({2'b00, stored(8'h20)});
        exp_words.push_back({2'b01, stored(8'h30)});
        exp_pkts.push_back({1'b0, 16'd3});
        rx_active = 1'b1;
        tick();
        send_bytes(24'h302010);
        rx_valid = 1'b0; rx_active = 1'b0; fifo_full = 1'b1;
        repeat (5) tick();
        check("stall_writes", 32'(n_writes - w0), 32'd2);
        check("stall_done", 32'(n_done - d0), 32'd0);
        fifo_full = 1'b0;
        tick();
        check("release_writes", 32'(n_writes - w0), 32'd3);
        check("release_done", 32'(n_done - d0), 32'd1);
        repeat (2) tick();

        // New burst rising during the stall: its bytes overflow and it ends in an abort word.
        w0 = n_writes; d0 = n_done; o0 = n_ovf;
        exp_words.push_back({2'b00, stored(8'h10)});
        exp_words.push_back({2'b00, stored(8'h20)});
        exp_words.push_back({2'b01, stored(8'h30)});
        exp_pkts.push_back({1'b0, 16'd3});
        exp_words.push_back(10'h300);
        exp_pkts.push_back({1'b1, 16'd0});
        rx_active = 1'b1;
        tick();
        send_bytes(24'h302010);
        rx_valid = 1'b0; rx_active = 1'b0; fifo_full = 1'b1;
        tick();
        rx_active = 1'b1;
        tick();
        rx_valid = 1'b1; rx_data = 8'h77;
        tick();
        rx_data = 8'h88; fifo_full = 1'b0;
        tick();
        end_burst();
        repeat (4) tick();
        check("overlap_writes", 32'(n_writes - w0), 32'd4);
        check("overlap_done", 32'(n_done - d0), 32'd2);
        check("overlap_ovf", 32'(n_ovf - o0), 32'd2);

        // Length counter saturation.
        d0 = n_done;
        for (int i = 0; i < 70000; i++) begin
            exp_words.push_back({1'b0, (i == 69999), stored(8'(i))});
        end
        exp_pkts.push_back({1'b0, 16'hFFFF});
        rx_active = 1'b1;
        tick();
        for (int i = 0; i < 70000; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            tick();
        end
        end_burst();
        repeat (4) tick();
        check("sat_done", 32'(n_done - d0), 32'd1);
        check("sat_len_held", 32'(pkt_len), 32'hFFFF);

        // Reset in the middle of a burst; the rest of that burst must be ignored.
        exp_words.push_back({2'b00, stored(8'hC1)});
        exp_words.push_back({2'b00, stored(8'hC2)});
        rx_active = 1'b1;
        tick();
        send_bytes(24'hC3C2C1);
        rx_data = 8'hC4;
        rst_n = 1'b0;
        tick();
        check_zero_outputs("midreset");
        tick();
        rst_n = 1'b1;
        w0 = n_writes; d0 = n_done; o0 = n_ovf;
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'(8'hD0 + i);
            tick();
        end
        rx_valid = 1'b0;
        repeat (3) tick();
        check("postreset_writes", 32'(n_writes - w0), 32'd0);
        check("postreset_done", 32'(n_done - d0), 32'd0);
        check("postreset_ovf", 32'(n_ovf - o0), 32'd0);
        end_burst();
        tick();
        run_vec(vecs[5], 5);

        check("scoreboard_left", 32'(exp_words.size() + exp_pkts.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lane_to_fifo_bridge.md
# lane_to_fifo_bridge

Receive-side counterpart of the lane TX bridge. Takes the byte stream delivered by a MIPI D-PHY lane receiver during one burst and writes it into the RX FIFO. Each FIFO word is tagged with end-of-packet and error flags, and one status pulse is produced per burst. Sits between the lane deserializer and the packet-parsing FIFO in the DSI receive path.

## Interface
Parameters:
- LEN_W, 16, width of burst length counter/status (saturates at all-ones)

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous reset, active low
- rx_active  in  1  lane burst in progress (HS/LP data phase)
- rx_valid  in  1  rx_data holds a new byte this cycle; ignored while rx_active=0
- rx_data  in  8  received byte
- rx_err  in  1  lane sync/escape error; ignored while rx_active=0
- fifo_full  in  1  RX FIFO cannot accept a write this cycle
- fifo_write  out  1  write strobe; combinational from state/inputs
- fifo_data  out  10  [7:0] byte, [8] last, [9] err
- pkt_done  out  1  one-cycle pulse when a burst's final word is written
- pkt_len  out  LEN_W  bytes accepted in that burst; valid with pkt_done, held until next pkt_done
- pkt_err  out  1  burst ended with error/overflow; valid with pkt_done
- overflow  out  1  one-cycle pulse when a received byte is lost

## Operation
- One-byte hold register. A byte is written only when its successor arrives (last=0) or the burst ends (last=1).
- States:
  - IDLE: hold empty, len=0. rx_active=1 -> RECV.
  - RECV, rx_valid=1:
    - hold full and !fifo_full: write hold with last=0; load new byte; len+1.
    - hold full and fifo_full: overflow pulse; -> DROP.
    - hold empty: load byte; len+1.
  - RECV, rx_err=1 (takes priority over rx_valid): -> DROP.
  - RECV, rx_active=0: hold full -> FLUSH; hold empty (zero-byte burst) -> IDLE, no pkt_done.
  - FLUSH: when !fifo_full, write hold with last=1, err=0; pkt_done; -> IDLE.
    - rx_valid bytes arriving in FLUSH are discarded with an overflow pulse each; flush then goes to DROP, not IDLE.
  - DROP: discard all bytes and clear hold. When rx_active=0 -> ABORT.
  - ABORT: when !fifo_full, write data 0x00 with last=1, err=1; pkt_done with pkt_err=1; -> IDLE.
- len increments only on accepted bytes and saturates at 2^LEN_W-1.
- Reset mid-burst: everything returns to IDLE. The remainder of that burst is ignored until rx_active is seen low, then high again.

## Timing
- Reset values: fifo_write=0, fifo_data=0, pkt_done=0, pkt_len=0, pkt_err=0, overflow=0; state IDLE, hold empty.
- fifo_write is asserted in the same cycle the next byte is presented. fifo_data comes from the hold register and is therefore registered.
- Final byte is written no earlier than the first cycle after rx_active is sampled low. It stalls there while fifo_full=1.
- pkt_done is coincident with the write of the last=1 word.
- Back-to-back bursts: rx_active may rise the cycle after it fell.
  - If the bridge is still in FLUSH/ABORT, that burst's bytes are overflowed.
  - Otherwise, in IDLE the rising edge is taken immediately.

## Configuration
- LANE_RX_BIT_REVERSE_EN:
  - Defined: rx_data bit i is stored as bit 7-i, matching the TX bridge's bit order so a TX→RX loopback reproduces the original bytes.
  - Undefined: bytes are stored unmodified.

## Structure
- Package dsi_lane_pkg holds:
  - state encoding (IDLE, RECV, FLUSH, DROP, ABORT);
  - FIFO word field positions (LAST_BIT=8, ERR_BIT=9);
  - the bit-reverse function, shared with the TX bridge.
- No sub-module; a single module with one FSM and the hold register.

## Test plan
- Burst of 0x01,0x02,0x03 with fifo_full=0 -> three writes with last=0,0,1. pkt_done once, pkt_len=3, pkt_err=0. With LANE_RX_BIT_REVERSE_EN, stored bytes are 0x80,0x40,0xC0.
- Single-byte burst 0xA5 -> one write 0xA5, last=1, pkt_len=1. Zero-byte burst -> no write, no pkt_done.
- fifo_full=1 when the 2nd byte arrives in a 4-byte burst -> overflow pulse, remaining bytes dropped. After rx_active falls and the FIFO drains, word 0x00 with last=1, err=1 is written; pkt_err=1.
- rx_err during byte 2 of 5 -> DROP, then ABORT terminator with err=1; next clean burst is received normally.
- fifo_full held 5 cycles after burst end -> final write delayed exactly until fifo_full=0. A new burst starting during the stall overflows its bytes and ends with an ABORT terminator.
- 70000-byte burst -> pkt_len saturates at 0xFFFF; rst_n asserted mid-burst -> all outputs 0 and no further writes until the next rx_active rising edge.
